// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared states, constants and byte-select helper for the SPI flash read slave
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ_DEFAULT = 8'h03;
    localparam int         SYNC_STAGES      = 2;
    localparam logic [1:0] RSP_TIMEOUT      = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_FETCH  = 3'd3,
        ST_DATA   = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall detection on the synchronized level
module spi_sync_edge
    import spi_flash_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_flash_slave.sv
// rtl/spi_flash_slave.sv - SPI mode-0 flash read slave serving bytes from a 32-bit word memory port
module spi_flash_slave
    import spi_flash_pkg::*;
#(
    parameter logic [7:0] CMD_READ = CMD_READ_DEFAULT,
    parameter int         ADDR_W   = 24
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              cmd_err,
    output logic              data_err
);

    localparam int               CNT_W     = $clog2(ADDR_W + 9);
    localparam logic [CNT_W-1:0] CMD_BITS  = CNT_W'(8);
    localparam logic [CNT_W-1:0] ADDR_BITS = CNT_W'(ADDR_W);

    logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .resetn  (resetn),
        .i_async (spi_clk),
        .o_level (w_sclk_level_unused),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .resetn  (resetn),
        .i_async (spi_cs_n),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .resetn  (resetn),
        .i_async (spi_mosi),
        .o_level (w_mosi),
        .o_rise  (w_mosi_rise_unused),
        .o_fall  (w_mosi_fall_unused)
    );

    state_t            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [ADDR_W-2:0] r_sh;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_word;
    logic [31:0]       r_next_word;
    logic [7:0]        r_tx;
    logic [2:0]        r_tx_bit;
    logic [1:0]        r_wait;
    logic              r_pf_busy;
    logic [1:0]        r_pf_wait;
    logic [1:0]        r_arm_cnt;
    logic              r_armed;
    logic              r_miso;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_busy;
    logic              r_cmd_err;
    logic              r_data_err;

    logic [ADDR_W-1:0] w_sh_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic [ADDR_W-3:0] w_next_word_idx;
    logic              w_rsp_ok;
    logic [31:0]       w_fetch_word;

    assign w_sh_next       = {r_sh, w_mosi};
    assign w_cnt_next      = r_bit_cnt + CNT_W'(1);
    assign w_fetch_addr    = {w_sh_next[ADDR_W-1:2], 2'b00};
    assign w_next_word_idx = r_addr[ADDR_W-1:2] + (ADDR_W-2)'(1);
    // A response in the request cycle itself is not accepted, which keeps a
    // follow-up prefetch from landing in the cycle right after a request.
    assign w_rsp_ok        = mem_rvalid & ~r_mem_req;
    assign w_fetch_word    = w_rsp_ok ? mem_rdata : 32'hFFFF_FFFF;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_sh        <= '0;
            r_addr      <= '0;
            r_word      <= '0;
            r_next_word <= '0;
            r_tx        <= '0;
            r_tx_bit    <= '0;
            r_wait      <= '0;
            r_pf_busy   <= 1'b0;
            r_pf_wait   <= '0;
            r_arm_cnt   <= '0;
            r_armed     <= 1'b0;
            r_miso      <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_busy      <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_data_err  <= 1'b0;
        end else begin
            r_mem_req  <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_data_err <= 1'b0;

            // Only a cs_n level seen high after the synchronizers refill arms the first transaction.
            if (r_arm_cnt != 2'd3) begin
                r_arm_cnt <= r_arm_cnt + 2'd1;
            end else if (w_cs_level) begin
                r_armed <= 1'b1;
            end

            if (r_pf_busy) begin
                if (w_rsp_ok) begin
                    r_next_word <= mem_rdata;
                    r_pf_busy   <= 1'b0;
                end else if (r_pf_wait == RSP_TIMEOUT) begin
                    r_next_word <= 32'hFFFF_FFFF;
                    r_pf_busy   <= 1'b0;
                    r_data_err  <= 1'b1;
                end else begin
                    r_pf_wait <= r_pf_wait + 2'd1;
                end
            end

            if (w_cs_rise) begin
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
                r_miso    <= 1'b1;
                r_pf_busy <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall && r_armed) begin
                            r_state   <= ST_CMD;
                            r_busy    <= 1'b1;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_sh      <= w_sh_next[ADDR_W-2:0];
                            r_bit_cnt <= w_cnt_next;
                            if (w_cnt_next == CMD_BITS) begin
                                r_bit_cnt <= '0;
                                if (w_sh_next[7:0] == CMD_READ) begin
                                    r_state <= ST_ADDR;
                                end else begin
                                    r_state   <= ST_IGNORE;
                                    r_cmd_err <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_sclk_rise) begin
                            r_sh      <= w_sh_next[ADDR_W-2:0];
                            r_bit_cnt <= w_cnt_next;
                            if (w_cnt_next == ADDR_BITS) begin
                                r_addr     <= w_sh_next;
                                r_state    <= ST_FETCH;
                                r_mem_req  <= 1'b1;
                                r_mem_addr <= w_fetch_addr;
                                r_wait     <= '0;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (w_rsp_ok || r_wait == RSP_TIMEOUT) begin
                            r_word     <= w_fetch_word;
                            r_tx       <= word_byte(w_fetch_word, r_addr[1:0]);
                            r_tx_bit   <= '0;
                            r_data_err <= ~w_rsp_ok;
                            r_state    <= ST_DATA;
                            if (r_addr[1:0] == 2'd3) begin
                                r_mem_req  <= 1'b1;
                                r_mem_addr <= {w_next_word_idx, 2'b00};
                                r_pf_busy  <= 1'b1;
                                r_pf_wait  <= '0;
                            end
                        end else begin
                            r_wait <= r_wait + 2'd1;
                        end
                    end
                    ST_DATA: begin
                        if (w_sclk_fall) begin
                            r_miso <= r_tx[7];
                            if (r_tx_bit == 3'd7) begin
                                r_tx_bit <= '0;
                                r_addr   <= r_addr + ADDR_W'(1);
                                if (r_addr[1:0] == 2'd3) begin
                                    r_word <= r_next_word;
                                    r_tx   <= r_next_word[7:0];
                                end else begin
                                    r_tx <= word_byte(r_word, r_addr[1:0] + 2'd1);
                                end
                                // Offset 3 starts shifting next: fetch the following word now.
                                if (r_addr[1:0] == 2'd2) begin
                                    r_mem_req  <= 1'b1;
                                    r_mem_addr <= {w_next_word_idx, 2'b00};
                                    r_pf_busy  <= 1'b1;
                                    r_pf_wait  <= '0;
                                end
                            end else begin
                                r_tx     <= {r_tx[6:0], 1'b0};
                                r_tx_bit <= r_tx_bit + 3'd1;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        r_miso <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spi_miso = r_miso;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign busy     = r_busy;
    assign cmd_err  = r_cmd_err;
    assign data_err = r_data_err;

endmodule
